// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU writeback trace buffer.
// An entry is {timestamp, drop flag, dest, pc, data}. Each entry leaves the block as three 32-bit words.
package cpu_trace_pkg;

    localparam logic [7:0] TRACE_MARKER = 8'hA5;

    localparam int unsigned W0_TS_LSB     = 0;
    localparam int unsigned W0_DEST_LSB   = 16;
    localparam int unsigned W0_DROP_BIT   = 23;
    localparam int unsigned W0_MARKER_LSB = 24;

    localparam int unsigned ENTRY_W = 16 + 1 + 5 + 32 + 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W0   = 2'd1,
        W1   = 2'd2,
        W2   = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [15:0] ts;
        logic        drop;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] data;
    } trace_entry_t;

    function automatic logic [31:0] build_w0(input trace_entry_t e);
        logic [31:0] w;
        w = 32'd0;
        w[W0_MARKER_LSB +: 8] = TRACE_MARKER;
        w[W0_DROP_BIT]        = e.drop;
        w[W0_DEST_LSB +: 5]   = e.dest;
        w[W0_TS_LSB +: 16]    = e.ts;
        return w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace entries. It accepts a push while full when a pop happens in the same cycle.
module trace_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int WIDTH  = 86,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  pop_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full     = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty    = (count_q == {(ADDR_W+1){1'b0}});
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {(ADDR_W+1){1'b0}};
        end else if (clear) begin
            wr_ptr_q <= {ADDR_W{1'b0}};
            rd_ptr_q <= {ADDR_W{1'b0}};
            count_q  <= {(ADDR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The storage array is not reset. Reads are gated by occupancy.
    always_ff @(posedge clock) begin
        if (push_ok_s && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Timestamps CPU register writebacks, buffers them and serializes each one as three words to a host.
// Overflow does not stall the CPU. Lost events are counted, and the next stored entry is flagged.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trace_en,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [4:0]        wr_dest,
    input  logic [31:0]       wr_data,
    input  logic [31:0]       pc,
    output logic [31:0]       out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic [15:0]       dropped
);

    trace_state_t     state_q, state_d;
    logic [15:0]      timestamp_q, timestamp_d;
    logic [15:0]      dropped_q, dropped_d;
    logic             drop_pending_q, drop_pending_d;

    logic             capture_s;
    logic             pop_s;
    logic             accept_s;
    logic             drop_s;
    logic             full_s;
    logic             empty_s;
    logic [ADDR_W:0]  count_s;
    trace_entry_t     new_entry_s;
    trace_entry_t     head_s;

    assign capture_s = trace_en && wr_en && (wr_dest != 5'd0);
    assign pop_s     = (state_q == W2) && out_ready;
    assign accept_s  = capture_s && (!full_s || pop_s);
    assign drop_s    = capture_s && full_s && !pop_s;

    assign new_entry_s = '{ts: timestamp_q, drop: drop_pending_q, dest: wr_dest, pc: pc, data: wr_data};

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .push      (accept_s),
        .push_data (new_entry_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Timestamp, saturating drop counter and the flag for the next entry after an overflow.
    always_comb begin
        timestamp_d    = timestamp_q + 16'd1;
        dropped_d      = dropped_q;
        drop_pending_d = drop_pending_q;
        if (drop_s) begin
            if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
            end else begin
                dropped_d = dropped_q;
            end
            drop_pending_d = 1'b1;
        end else if (accept_s) begin
            drop_pending_d = 1'b0;
        end else begin
            drop_pending_d = drop_pending_q;
        end
    end

    // Serializer next state. After the last word, continue only if an entry remains, including one pushed this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty_s) state_d = W0;
                else          state_d = IDLE;
            end
            W0: begin
                if (out_ready) state_d = W1;
                else           state_d = W0;
            end
            W1: begin
                if (out_ready) state_d = W2;
                else           state_d = W1;
            end
            W2: begin
                if (out_ready) begin
                    if ((count_s > (ADDR_W+1)'(1)) || accept_s) state_d = W0;
                    else                                        state_d = IDLE;
                end else begin
                    state_d = W2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timestamp and drop bookkeeping registers. Clear flushes everything at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            timestamp_q    <= 16'd0;
            dropped_q      <= 16'd0;
            drop_pending_q <= 1'b0;
        end else if (clear) begin
            state_q        <= IDLE;
            timestamp_q    <= 16'd0;
            dropped_q      <= 16'd0;
            drop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timestamp_q    <= timestamp_d;
            dropped_q      <= dropped_d;
            drop_pending_q <= drop_pending_d;
        end
    end

    // The output word is selected from the registered state and the FIFO head, so it holds steady under backpressure.
    always_comb begin
        case (state_q)
            W0:      out_word = build_w0(head_s);
            W1:      out_word = head_s.pc;
            W2:      out_word = head_s.data;
            default: out_word = 32'd0;
        endcase
    end

    assign out_valid = (state_q != IDLE);
    assign count     = count_s;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Randomized and directed bench for cpu_trace_buffer.
// A queue-based model of the captured events and the word-by-word delivery is stepped at every clock edge.
module tb_cpu_trace_buffer;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        trace_en, clear, wr_en, out_ready;
    logic [4:0]  wr_dest;
    logic [31:0] wr_data, pc;
    logic [31:0] out_word;
    logic        out_valid;
    logic [4:0]  count;
    logic [15:0] dropped;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    cpu_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .trace_en  (trace_en),
        .clear     (clear),
        .wr_en     (wr_en),
        .wr_dest   (wr_dest),
        .wr_data   (wr_data),
        .pc        (pc),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .dropped   (dropped)
    );

    typedef struct {
        logic [15:0] ts;
        bit          drop;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] data;
    } ev_t;

    ev_t         m_q[$];
    bit          m_active;
    int          m_widx;
    int          m_dropped;
    bit          m_pend;
    logic [15:0] m_ts;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_word();
        ev_t e;
        if (!m_active || m_q.size() == 0) return 32'd0;
        e = m_q[0];
        case (m_widx)
            0:       return (32'hA5 << 24) | (32'(e.drop) << 23) | (32'(e.dest) << 16) | 32'(e.ts);
            1:       return e.pc;
            default: return e.data;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active  = 1'b0;
        m_widx    = 0;
        m_dropped = 0;
        m_pend    = 1'b0;
        m_ts      = 16'd0;
    endtask

    task automatic model_step();
        int  n;
        bit  hs, pop, cap;
        ev_t e;
        if (!reset || clear) begin
            model_reset();
            return;
        end
        n   = m_q.size();
        hs  = m_active && out_ready;
        pop = hs && (m_widx == 2);
        cap = trace_en && wr_en && (wr_dest != 5'd0);
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            if (n < DEPTH || pop) begin
                e.ts = m_ts; e.drop = m_pend; e.dest = wr_dest; e.pc = pc; e.data = wr_data;
                m_q.push_back(e);
                m_pend = 1'b0;
            end else begin
                if (m_dropped < 65535) m_dropped++;
                m_pend = 1'b1;
            end
        end
        if (!m_active) begin
            m_active = (n != 0);
            m_widx   = 0;
        end else if (hs) begin
            if (m_widx < 2) m_widx++;
            else begin
                m_widx   = 0;
                m_active = (m_q.size() != 0);
            end
        end
        m_ts = m_ts + 16'd1;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 32'(out_valid), 32'(m_active));
        check_eq("out_word", out_word, m_word());
        check_eq("count", 32'(count), 32'(m_q.size()));
        check_eq("dropped", 32'(dropped), 32'(m_dropped));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic capture(input logic [4:0] d, input logic [31:0] p, input logic [31:0] v);
        wr_en = 1'b1; wr_dest = d; pc = p; wr_data = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int i;
        for (i = 0; i < 20 && !out_valid; i++) tick();
        if (!out_valid) check_eq(tag, 32'(out_valid), 32'd1);
    endtask

    int          delivered;
    int          saved_drop;
    logic [31:0] last_word;

    initial begin
        reset = 1'b0; trace_en = 1'b0; clear = 1'b0; wr_en = 1'b0;
        wr_dest = 5'd0; wr_data = 32'd0; pc = 32'd0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_outputs();
        reset = 1'b1;
        trace_en = 1'b1;
        out_ready = 1'b1;

        // Test 1: a single event captured at timestamp 5.
        for (int i = 0; i < 50 && m_ts != 16'd5; i++) tick();
        capture(5'd8, 32'h0000_0040, 32'h1234_5678);
        tick();
        check_eq("t1_w0", out_word, 32'hA508_0005);
        tick();
        check_eq("t1_w1", out_word, 32'h0000_0040);
        tick();
        check_eq("t1_w2", out_word, 32'h1234_5678);
        tick();
        check_eq("t1_count_empty", 32'(count), 32'd0);
        check_eq("t1_idle", 32'(out_valid), 32'd0);

        // Test 2: writes to register zero are ignored.
        wr_en = 1'b1; wr_dest = 5'd0;
        repeat (10) tick();
        wr_en = 1'b0;
        check_eq("t2_count", 32'(count), 32'd0);
        check_eq("t2_valid", 32'(out_valid), 32'd0);

        // Test 3: overflow while the host stalls.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) capture(5'd1, $urandom, $urandom);
        check_eq("t3_count_full", 32'(count), 32'd16);
        check_eq("t3_dropped", 32'(dropped), 32'd3);
        out_ready = 1'b1;
        repeat (60) tick();
        check_eq("t3_drained", 32'(count), 32'd0);
        capture(5'd2, $urandom, $urandom);
        wait_valid("t3_wait1");
        check_eq("t3_drop_flag_set", 32'(out_word[23]), 32'd1);
        repeat (3) tick();
        capture(5'd3, $urandom, $urandom);
        wait_valid("t3_wait2");
        check_eq("t3_drop_flag_clear", 32'(out_word[23]), 32'd0);
        repeat (4) tick();

        // Test 4: ready toggles every cycle during a two-entry drain.
        out_ready = 1'b0;
        capture(5'd4, $urandom, $urandom);
        capture(5'd5, $urandom, $urandom);
        tick();
        delivered = 0;
        for (int i = 0; i < 40 && delivered < 6; i++) begin
            out_ready = i[0];
            if (out_valid && out_ready) delivered++;
            tick();
        end
        check_eq("t4_words_delivered", 32'(delivered), 32'd6);
        out_ready = 1'b1;
        tick();
        check_eq("t4_count", 32'(count), 32'd0);

        // Test 5: push and pop in the same cycle while full.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) capture(5'(1 + (i % 31)), $urandom, $urandom);
        tick();
        check_eq("t5_full", 32'(count), 32'd16);
        saved_drop = m_dropped;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && !(m_active && m_widx == 2); i++) tick();
        capture(5'd9, 32'h0000_0ABC, 32'hC011_1DE5);
        check_eq("t5_count_kept", 32'(count), 32'd16);
        check_eq("t5_dropped_kept", 32'(dropped), 32'(saved_drop));
        last_word = 32'd0;
        for (int i = 0; i < 80 && (count != 5'd0 || out_valid); i++) begin
            if (out_valid && out_ready) last_word = out_word;
            tick();
        end
        check_eq("t5_last_in_order", last_word, 32'hC011_1DE5);

        // Test 6a: clear while the second word is on the bus.
        capture(5'd6, $urandom, $urandom);
        wait_valid("t6_wait");
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("t6_clear_valid", 32'(out_valid), 32'd0);
        check_eq("t6_clear_count", 32'(count), 32'd0);
        check_eq("t6_clear_dropped", 32'(dropped), 32'd0);

        // Test 6b: asynchronous reset mid-drain.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) capture(5'd7, $urandom, $urandom);
        out_ready = 1'b1;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t6_rst_word", out_word, 32'd0);
        check_eq("t6_rst_count", 32'(count), 32'd0);
        check_eq("t6_rst_dropped", 32'(dropped), 32'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // Random traffic, with occasional clears, checked against the model every cycle.
        for (int i = 0; i < 1500; i++) begin
            trace_en  = ($urandom_range(0, 9) != 0);
            wr_en     = ($urandom_range(0, 2) != 0);
            wr_dest   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            wr_data   = $urandom;
            pc        = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 99) == 0);
            tick();
        end
        clear = 1'b0; wr_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
